// File: rtl/nanov_periph_bus_if.sv
// nanov_periph_bus_if
//   Load/store bus between the nanoV CPU external data port and the
//   peripheral block.
//   addr_in       : load/store address, qualified by store_addr_in
//   data_in       : store data, qualified by store_data_in
//   store_addr_in : one-cycle pulse, addr_in is a new load/store address
//   store_data_in : one-cycle pulse, data_in is store data for the latched address
//   data_read_in  : one-cycle pulse, CPU has consumed data_out for a load
//   data_out      : load read data, captured on store_addr_in
//   master modport = CPU side, slave modport = peripheral side.
interface nanov_periph_bus_if;
  logic [31:0] addr_in;
  logic [31:0] data_in;
  logic        store_addr_in;
  logic        store_data_in;
  logic        data_read_in;
  logic [31:0] data_out;

  modport master (
    output addr_in, data_in, store_addr_in, store_data_in, data_read_in,
    input  data_out
  );

  modport slave (
    input  addr_in, data_in, store_addr_in, store_data_in, data_read_in,
    output data_out
  );
endinterface

// File: rtl/nanov_periph_bus.sv
// nanov_periph_bus
//   Memory-mapped peripherals in the 0x10000xxx window behind the nanoV
//   CPU external data port: GPIO output register, synchronised GPIO input,
//   free-running cycle counter and an 8N1 UART with a 1-byte RX buffer.
//   Ports:
//     clk      : clock
//     rstn     : synchronous active-low reset
//     bus      : load/store bus (slave side), see nanov_periph_bus_if
//     gpio_out : GPIO output register
//     gpio_in  : asynchronous GPIO inputs
//     uart_tx  : UART transmit line, idle high
//     uart_rx  : asynchronous UART receive line
//   Register map (byte offset): 0x000 GPIO_OUT, 0x004 GPIO_IN, 0x008 CYCLES,
//   0x010 UART_DATA, 0x014 UART_STATUS {rx_overrun, rx_valid, tx_busy}.
module nanov_periph_bus #(
  parameter int CLKS_PER_BIT = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  nanov_periph_bus_if.slave        bus,
  output logic [7:0]               gpio_out,
  input  logic [7:0]               gpio_in,
  output logic                     uart_tx,
  input  logic                     uart_rx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  // Word offsets (byte offset >> 2)
  localparam logic [9:0] OFF_GPIO_OUT  = 10'd0;
  localparam logic [9:0] OFF_GPIO_IN   = 10'd1;
  localparam logic [9:0] OFF_CYCLES    = 10'd2;
  localparam logic [9:0] OFF_UART_DATA = 10'd4;
  localparam logic [9:0] OFF_UART_STAT = 10'd5;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Bus-side registers
  logic [31:0] data_out_reg;
  logic [7:0]  gpio_out_reg;
  logic [31:0] cycles_reg;
  logic        hit_reg;
  logic [9:0]  offset_reg;

  // Synchronisers
  logic [7:0]  gpio_meta_reg, gpio_sync_reg;
  logic        rx_meta_reg, rx_sync_reg, rx_prev_reg;

  // UART TX
  tx_state_t        tx_state_reg, tx_state_next;
  logic [CNT_W-1:0] tx_cnt_reg, tx_cnt_next;
  logic [2:0]       tx_bit_reg, tx_bit_next;
  logic [7:0]       tx_shift_reg, tx_shift_next;
  logic             tx_line;
  logic             tx_busy;
  logic             tx_start;

  // UART RX
  rx_state_t        rx_state_reg, rx_state_next;
  logic [CNT_W-1:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0]       rx_bit_reg, rx_bit_next;
  logic [7:0]       rx_shift_reg, rx_shift_next;
  logic             rx_done;
  logic [7:0]       rx_byte_reg;
  logic             rx_valid_reg, rx_valid_next;
  logic             rx_overrun_reg, rx_overrun_next;
  logic             rx_clear;

  // Address decode of the live address (for the read capture)
  logic        addr_hit;
  logic [9:0]  addr_off;
  logic [31:0] rd_mux;

  // Byte lanes and address bits the register map never looks at
  logic unused_bits;
  assign unused_bits = ^{bus.addr_in[1:0], bus.data_in[31:8]};

  assign addr_hit = (bus.addr_in[31:12] == 20'h10000);
  assign addr_off = bus.addr_in[11:2];

  // Writes and clears always target the previously latched address, which
  // makes a same-cycle store_addr_in/store_data_in pair behave correctly.
  assign tx_start = bus.store_data_in && hit_reg && (offset_reg == OFF_UART_DATA);
  assign rx_clear = bus.data_read_in  && hit_reg && (offset_reg == OFF_UART_DATA);

  assign tx_busy  = (tx_state_reg != TX_IDLE);

  always_comb begin
    rd_mux = '0;
    if (addr_hit) begin
      case (addr_off)
        OFF_GPIO_OUT:  rd_mux = {24'd0, gpio_out_reg};
        OFF_GPIO_IN:   rd_mux = {24'd0, gpio_sync_reg};
        OFF_CYCLES:    rd_mux = cycles_reg;
        OFF_UART_DATA: rd_mux = {24'd0, rx_byte_reg};
        OFF_UART_STAT: rd_mux = {29'd0, rx_overrun_reg, rx_valid_reg, tx_busy};
        default:       rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_out_reg  <= '0;
      gpio_out_reg  <= '0;
      cycles_reg    <= '0;
      hit_reg       <= 1'b0;
      offset_reg    <= '0;
      gpio_meta_reg <= '1;
      gpio_sync_reg <= '1;
      rx_meta_reg   <= 1'b1;
      rx_sync_reg   <= 1'b1;
      rx_prev_reg   <= 1'b1;
      rx_byte_reg   <= '0;
    end else begin
      cycles_reg    <= cycles_reg + 32'd1;
      gpio_meta_reg <= gpio_in;
      gpio_sync_reg <= gpio_meta_reg;
      rx_meta_reg   <= uart_rx;
      rx_sync_reg   <= rx_meta_reg;
      rx_prev_reg   <= rx_sync_reg;
      if (bus.store_addr_in) begin
        hit_reg      <= addr_hit;
        offset_reg   <= addr_off;
        data_out_reg <= rd_mux;
      end
      if (bus.store_data_in && hit_reg && (offset_reg == OFF_GPIO_OUT))
        gpio_out_reg <= bus.data_in[7:0];
      if (rx_done)
        rx_byte_reg <= rx_shift_reg;
    end
  end

  // ---------------- UART TX ----------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
    end
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    tx_line       = 1'b1;
    case (tx_state_reg)
      TX_IDLE: begin
        // Writes while busy fall through every other state and are dropped.
        if (tx_start) begin
          tx_state_next = TX_START;
          tx_cnt_next   = '0;
          tx_shift_next = bus.data_in[7:0];
        end
      end
      TX_START: begin
        tx_line = 1'b0;
        if (tx_cnt_reg == BIT_LAST) begin
          tx_state_next = TX_DATA;
          tx_cnt_next   = '0;
          tx_bit_next   = '0;
        end else begin
          tx_cnt_next = tx_cnt_reg + CNT_W'(1);
        end
      end
      TX_DATA: begin
        tx_line = tx_shift_reg[0];
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next   = '0;
          tx_shift_next = {1'b0, tx_shift_reg[7:1]};
          if (tx_bit_reg == 3'd7) tx_state_next = TX_STOP;
          else                    tx_bit_next   = tx_bit_reg + 3'd1;
        end else begin
          tx_cnt_next = tx_cnt_reg + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_reg == BIT_LAST) tx_state_next = TX_IDLE;
        else                        tx_cnt_next   = tx_cnt_reg + CNT_W'(1);
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  // ---------------- UART RX ----------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_state_reg   <= RX_IDLE;
      rx_cnt_reg     <= '0;
      rx_bit_reg     <= '0;
      rx_shift_reg   <= '0;
      rx_valid_reg   <= 1'b0;
      rx_overrun_reg <= 1'b0;
    end else begin
      rx_state_reg   <= rx_state_next;
      rx_cnt_reg     <= rx_cnt_next;
      rx_bit_reg     <= rx_bit_next;
      rx_shift_reg   <= rx_shift_next;
      rx_valid_reg   <= rx_valid_next;
      rx_overrun_reg <= rx_overrun_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    rx_done       = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        if (rx_prev_reg && !rx_sync_reg) begin
          rx_state_next = RX_START;
          rx_cnt_next   = '0;
        end
      end
      RX_START: begin
        // Mid-start-bit check: a line already back high was only a glitch.
        if (rx_cnt_reg == HALF_LAST) begin
          rx_cnt_next = '0;
          rx_bit_next = '0;
          rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_next = rx_cnt_reg + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_reg == BIT_LAST) begin
          rx_cnt_next   = '0;
          rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
          if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
          else                    rx_bit_next   = rx_bit_reg + 3'd1;
        end else begin
          rx_cnt_next = rx_cnt_reg + CNT_W'(1);
        end
      end
      RX_STOP: begin
        // A low stop bit is a framing error: the byte is dropped silently.
        if (rx_cnt_reg == BIT_LAST) begin
          rx_state_next = RX_IDLE;
          rx_done       = rx_sync_reg;
        end else begin
          rx_cnt_next = rx_cnt_reg + CNT_W'(1);
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  // A completing byte beats a same-cycle clear; the clear still consumes
  // the previous byte, so that case is not an overrun.
  always_comb begin
    rx_valid_next   = rx_valid_reg;
    rx_overrun_next = rx_overrun_reg;
    if (rx_done) begin
      rx_valid_next   = 1'b1;
      rx_overrun_next = rx_clear ? 1'b0 : (rx_overrun_reg | rx_valid_reg);
    end else if (rx_clear) begin
      rx_valid_next   = 1'b0;
      rx_overrun_next = 1'b0;
    end
  end

  assign bus.data_out = data_out_reg;
  assign gpio_out     = gpio_out_reg;
  assign uart_tx      = tx_line;

endmodule

// File: tb/tb_nanov_periph_bus.sv
// tb_nanov_periph_bus
//   Randomised bench for nanov_periph_bus. A transaction-level model tracks
//   the register map, the TX frame as a countdown over a 10-bit frame and the
//   RX buffer as per-frame events; a compare process checks uart_tx, gpio_out
//   and data_out every cycle, and directed sections pin literal values.
module tb_nanov_periph_bus;
  localparam int N = 32;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] gpio_out;
  logic [7:0] gpio_in = 8'h00;
  logic       uart_tx;
  logic       uart_rx = 1'b1;

  nanov_periph_bus_if bus();

  nanov_periph_bus #(.CLKS_PER_BIT(N)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .gpio_out (gpio_out),
    .gpio_in  (gpio_in),
    .uart_tx  (uart_tx),
    .uart_rx  (uart_rx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  logic        m_ready = 1'b0;
  logic [31:0] m_data_out, m_cycles, m_rd;
  logic [7:0]  m_gpio, m_h1, m_h2, m_rx_byte, m_tx_byte;
  logic        m_hit, m_rx_valid, m_rx_ovr, m_start;
  logic [9:0]  m_off;
  int          m_tx_left;   // cycles of the current TX frame still to go

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:12] != 20'h10000) return 32'd0;
    case (a[11:2])
      10'd0:   return {24'd0, m_gpio};
      10'd1:   return {24'd0, m_h2};
      10'd2:   return m_cycles;
      10'd4:   return {24'd0, m_rx_byte};
      10'd5:   return {29'd0, m_rx_ovr, m_rx_valid, (m_tx_left > 0)};
      default: return 32'd0;
    endcase
  endfunction

  // Line level implied by the frame {stop=1, byte, start=0}
  function automatic logic tx_expect();
    int idx;
    if (m_tx_left <= 0) return 1'b1;
    idx = (10 * N - m_tx_left) / N;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_tx_byte[idx-1];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      m_ready = 1'b1; m_data_out = 0; m_cycles = 0; m_gpio = 0;
      m_h1 = 8'hFF; m_h2 = 8'hFF; m_rx_byte = 0; m_tx_byte = 0;
      m_hit = 0; m_off = 0; m_rx_valid = 0; m_rx_ovr = 0; m_tx_left = 0;
    end else begin
      m_rd    = model_read(bus.addr_in);
      m_start = 1'b0;
      if (bus.store_data_in && m_hit) begin
        if (m_off == 10'd0) m_gpio = bus.data_in[7:0];
        if (m_off == 10'd4 && m_tx_left == 0) begin
          m_tx_byte = bus.data_in[7:0];
          m_start   = 1'b1;
        end
      end
      if (bus.data_read_in && m_hit && m_off == 10'd4) begin
        m_rx_valid = 0; m_rx_ovr = 0;
      end
      if (bus.store_addr_in) begin
        m_data_out = m_rd;
        m_hit = (bus.addr_in[31:12] == 20'h10000);
        m_off = bus.addr_in[11:2];
      end
      m_cycles = m_cycles + 32'd1;
      m_h2 = m_h1;
      m_h1 = gpio_in;
      if (m_tx_left > 0) m_tx_left--;
      if (m_start) m_tx_left = 10 * N;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (m_ready) begin
      check("uart_tx",  32'(uart_tx), 32'(tx_expect()));
      check("gpio_out", 32'(gpio_out), 32'(m_gpio));
      check("data_out", bus.data_out, m_data_out);
    end
  end

  // ---------------- stimulus helpers ----------------
  int t;   // cycle index inside directed TX section

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_load(input logic [31:0] a, output logic [31:0] d);
    bus.addr_in = a; bus.store_addr_in = 1'b1;
    tick();
    bus.store_addr_in = 1'b0;
    @(negedge clk);
    d = bus.data_out;
    tick();
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    bus.addr_in = a; bus.store_addr_in = 1'b1;
    tick();
    bus.store_addr_in = 1'b0;
    bus.data_in = d; bus.store_data_in = 1'b1;
    tick();
    bus.store_data_in = 1'b0;
  endtask

  task automatic do_ack();
    bus.data_read_in = 1'b1;
    tick();
    bus.data_read_in = 1'b0;
  endtask

  task automatic wait_to(input int target);
    while (t < target) begin tick(); t++; end
  endtask

  // Drive one 8N1 frame; the model learns of the byte once the frame is over.
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0; idle(N);
    for (int i = 0; i < 8; i++) begin uart_rx = b[i]; idle(N); end
    uart_rx = stop_bit; idle(N);
    uart_rx = 1'b1;
    if (stop_bit) begin
      m_rx_ovr   = m_rx_ovr | m_rx_valid;
      m_rx_valid = 1'b1;
      m_rx_byte  = b;
    end
    idle(4);
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] base;
    case ($urandom_range(0, 9))
      0: base = 32'h10000000;
      1: base = 32'h10000004;
      2: base = 32'h10000008;
      3: base = 32'h1000000C;
      4, 5: base = 32'h10000010;
      6: base = 32'h10000014;
      7: base = 32'h10000018;
      8: base = 32'h10000FFC;
      default: base = ($urandom_range(0, 1) != 0) ? 32'h20000010 : 32'h10001000;
    endcase
    return base | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [31:0] d;
  logic [9:0]  frame;

  initial begin
    bus.addr_in = 0; bus.data_in = 0;
    bus.store_addr_in = 0; bus.store_data_in = 0; bus.data_read_in = 0;
    repeat (4) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_data_out", bus.data_out, 32'd0);
    check("rst_gpio_out", 32'(gpio_out), 32'd0);
    check("rst_uart_tx",  32'(uart_tx), 32'd1);

    // CYCLES sampled in the 100th cycle after reset release
    repeat (100) @(posedge clk);
    #1 bus.addr_in = 32'h10000008; bus.store_addr_in = 1'b1;
    tick();
    bus.store_addr_in = 1'b0;
    @(negedge clk);
    check("cycles_at_100", bus.data_out, 32'd100);
    tick();

    do_load(32'h10000014, d); check("status_idle", d, 32'h0);

    // GPIO
    do_store(32'h10000000, 32'h000001A5);
    check("gpio_write", 32'(gpio_out), 32'hA5);
    do_load(32'h10000000, d); check("gpio_readback", d, 32'hA5);
    gpio_in = 8'h3C; idle(3);
    do_load(32'h10000004, d); check("gpio_in", d, 32'h3C);
    do_load(32'h20000004, d); check("nonhit_read", d, 32'h0);
    do_store(32'h20000000, 32'h77);
    check("nonhit_write", 32'(gpio_out), 32'hA5);

    // UART TX 0x55 with a dropped mid-frame write
    do_store(32'h10000010, 32'h55);
    t = 0;
    frame = {1'b1, 8'h55, 1'b0};
    for (int b = 0; b < 10; b++) begin
      wait_to(b * N + N / 2);
      check($sformatf("tx_bit%0d", b), 32'(uart_tx), 32'(frame[b]));
      if (b == 1) begin do_load(32'h10000014, d); t += 2; check("tx_busy", d, 32'h1); end
      if (b == 2) begin do_store(32'h10000010, 32'hFF); t += 2; end
    end
    wait_to(10 * N + 5);
    check("tx_done_line", 32'(uart_tx), 32'd1);
    do_load(32'h10000014, d); check("tx_done_status", d, 32'h0);

    // UART RX
    send_rx(8'hA3, 1'b1);
    do_load(32'h10000014, d); check("rx_status", d, 32'h2);
    do_load(32'h10000010, d); check("rx_data", d, 32'hA3);
    do_ack();
    do_load(32'h10000014, d); check("rx_cleared", d, 32'h0);
    send_rx(8'h3C, 1'b1);
    send_rx(8'hC5, 1'b1);
    do_load(32'h10000014, d); check("rx_overrun", d, 32'h6);
    do_load(32'h10000010, d); check("rx_second", d, 32'hC5);
    do_ack();
    do_load(32'h10000014, d); check("rx_ovr_cleared", d, 32'h0);
    uart_rx = 1'b0; idle(10); uart_rx = 1'b1; idle(3 * N);
    do_load(32'h10000014, d); check("rx_glitch", d, 32'h0);
    send_rx(8'h5A, 1'b0); idle(N);
    do_load(32'h10000014, d); check("rx_framing", d, 32'h0);

    // Reset in the middle of a TX frame
    do_store(32'h10000010, 32'h0F);
    idle(50);
    rstn = 1'b0; tick();
    check("rst_mid_tx", 32'(uart_tx), 32'd1);
    check("rst_mid_gpio", 32'(gpio_out), 32'd0);
    rstn = 1'b1; tick();

    // Randomised traffic
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          bus.addr_in       = pick_addr();
          bus.data_in       = $urandom;
          bus.store_addr_in = ($urandom_range(0, 1) != 0);
          bus.store_data_in = ($urandom_range(0, 1) != 0);
          bus.data_read_in  = ($urandom_range(0, 3) == 0);
          tick();
          bus.store_addr_in = 0; bus.store_data_in = 0; bus.data_read_in = 0;
        end
        4: begin gpio_in = 8'($urandom); tick(); end
        5: idle($urandom_range(1, 40));
        6: send_rx(8'($urandom), ($urandom_range(0, 5) != 0));
        7: do_load(pick_addr(), d);
        8: do_store(pick_addr(), $urandom);
        default: do_ack();
      endcase
    end
    idle(10 * N);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/nanov_periph_bus.md
Name: nanov_periph_bus

Overview:
- Memory-mapped peripheral block directly downstream of the nanoV CPU's external data port.
- Decodes addresses in the 0x10000xxx window from load/store traffic.
- Holds an 8-bit GPIO output register, synchronises an 8-bit GPIO input and runs a free-running cycle counter.
- Contains an 8N1 UART (TX + RX with 1-byte receive buffer).
- Returns load data on a 32-bit bus the CPU samples one bit per clock.

Parameters:
- CLKS_PER_BIT, 32, UART bit period in clk cycles; must be >=4 and even.

Ports:
- clk  input  1  clock
- rstn  input  1  synchronous active-low reset
- addr_in  input  32  load/store address, valid when store_addr_in=1
- data_in  input  32  store data, valid when store_data_in=1
- store_addr_in  input  1  one-cycle pulse: addr_in is a load/store address
- store_data_in  input  1  one-cycle pulse: data_in is store data for the last latched address
- data_read_in  input  1  one-cycle pulse: CPU has finished consuming data_out for a load
- data_out  output  32  load read data (to CPU ext_data_in)
- gpio_out  output  8  GPIO output register
- gpio_in  input  8  asynchronous GPIO inputs
- uart_tx  output  1  UART transmit line, idle high
- uart_rx  input  1  asynchronous UART receive line

Behaviour:
- Reset is synchronous, active-low; clock is clk. All state is synchronous to clk.
- Reset values:
  - data_out=0, gpio_out=0, uart_tx=1, cycle counter=0.
  - rx_valid=0, rx_overrun=0; TX and RX FSMs in IDLE.
  - Latched address: hit=0, offset=0.
  - gpio_in and uart_rx synchronisers reset to all 1s.
- Reset mid-frame aborts the frame; uart_tx goes high the following cycle.
- Decode: hit = (addr_in[31:12] == 20'h10000); offset = addr_in[11:2].
- Register map (byte offset). Unmapped or non-hit addresses read 0 and ignore writes.
  - 0x000 GPIO_OUT: RW, bits[7:0].
  - 0x004 GPIO_IN: RO, 2-flop synchronised gpio_in in bits[7:0].
  - 0x008 CYCLES: RO, 32-bit counter, +1 every clk, wraps 0xFFFFFFFF->0.
  - 0x010 UART_DATA:
    - Write: bits[7:0] start TX if TX idle; dropped silently if busy.
    - Read: rx byte in bits[7:0].
  - 0x014 UART_STATUS: RO. bit0 tx_busy, bit1 rx_valid, bit2 rx_overrun.
- On a store_addr_in cycle:
  - Latch hit and offset.
  - Capture the read mux for addr_in (combinational decode of addr_in, not the latched value) into data_out.
  - data_out is therefore valid the very next cycle and held until the next store_addr_in.
  - CYCLES reads return the counter value in the store_addr_in cycle.
- store_data_in: write data_in to the latched offset if the latched hit=1.
  - gpio_out updates the next cycle.
  - A UART_DATA write takes effect next cycle: tx_busy=1 and uart_tx drives the start bit.
- data_read_in with latched hit and offset=UART_DATA: clear rx_valid and rx_overrun next cycle. Any other latched address: no side effects.
- store_addr_in and store_data_in in the same cycle: the write uses the previously latched address; the new address is then latched.
- UART TX FSM: IDLE -> START -> DATA (8 bits, LSB first) -> STOP -> IDLE.
  - Each state/bit lasts CLKS_PER_BIT cycles.
  - tx_busy=1 from START through end of STOP.
  - Back-to-back writes are accepted only in IDLE.
- UART RX FSM: IDLE -> START -> DATA -> STOP -> IDLE, operating on the synchronised rx line.
  - IDLE->START on a falling edge.
  - START: sample at CLKS_PER_BIT/2; if high return to IDLE (glitch).
  - DATA: 8 samples spaced CLKS_PER_BIT apart, LSB first.
  - STOP: if sample high, load rx byte and set rx_valid; if low, discard (framing error, no flag).
  - Byte completes while rx_valid=1: overwrite byte, set rx_overrun.
  - Byte completion and clearing data_read_in in the same cycle: completion wins; rx_valid stays 1, overrun not set.

Test Plan:
- Reset, then idle 10 cycles -> data_out=0, gpio_out=0, uart_tx=1; status read returns 0x00000000.
- GPIO_OUT write: store_addr_in with addr 0x10000000, then store_data_in with data 0x000001A5 -> gpio_out=0xA5; load of 0x10000000 -> data_out=0x000000A5 the cycle after store_addr_in.
- gpio_in=0x3C held 3 cycles, then load 0x10000004 -> data_out=0x3C. Load 0x20000004 -> data_out=0 and no side effects.
- Cycle counter: store_addr_in with 0x10000008 at cycle 100 after reset release -> data_out=100. Force counter to 0xFFFFFFFF -> next value 0.
- UART TX: write 0x55 to 0x10000010 -> uart_tx is low for 32 cycles, then 1,0,1,0,1,0,1,0 (32 each), then high. Status bit0=1 throughout. A second write mid-frame is dropped.
- UART RX: drive frame 0xA3 at 32 clk/bit -> status=0x2, data read=0xA3, and after data_read_in status=0. Two frames without a read -> status=0x6, data = second byte. A 10-cycle low glitch -> no byte received.
